clic_irq_scanner: RTL and testbench
===================================

// Module: clic_irq_scanner
// PURPOSE
// - Sequential CLIC arbiter sitting directly upstream of the core's interrupt/CSR path.
// - Sweeps all NumSrc interrupt sources, ChunkSize per cycle.
// - Selects the enabled+pending source with the highest intctl value; ties go to the lowest id.
// - Offers that source to the core if its level exceeds the current threshold.
// - Trades a full-width comparator tree for a multi-cycle scan, so timing closes at core frequency.
// PARAMETERS
// - NumSrc      256  number of CLIC sources; must be a multiple of ChunkSize
// - IntCtlBits  8    width of the per-source clicintctl level/priority field
// - ChunkSize   16   sources compared per scan cycle; power of two
// - SrcW        $clog2(NumSrc)  id width (derived, localparam)
// PORTS
// - clk_i            in   1                   clock
// - rst_i            in   1                   synchronous, active-high reset
// - pending_i        in   NumSrc              clicintip per source
// - enable_i         in   NumSrc              clicintie per source
// - ctl_i            in   NumSrc*IntCtlBits   clicintctl; source k at bits [k*IntCtlBits +: IntCtlBits]
// - thresh_i         in   IntCtlBits          effective interrupt threshold, max(mintthresh, current mil)
// - irq_valid_o      out  1                   interrupt offered to core
// - irq_id_o         out  SrcW                offered source id
// - irq_level_o      out  IntCtlBits          offered source intctl
// - irq_ready_i      in   1                   core takes the offered interrupt this cycle
// - scan_busy_o      out  1                   sweep in progress (perf/debug)
// - irq_shv_o        out  1                   selective-hw-vector bit of offered source (only with macro)
// - shv_i            in   NumSrc              per-source clicintattr.shv (only with macro)
// BEHAVIOUR
// - Reset values: irq_valid_o=0, irq_id_o=0, irq_level_o=0, scan_busy_o=0, irq_shv_o=0.
// - Reset also puts the FSM in IDLE and clears the chunk counter and best-candidate register.
// - Reset mid-scan or mid-offer abandons the operation; nothing is retained.
// - FSM states: IDLE, SCAN, OFFER.
// - IDLE -> SCAN: the cycle after rst_i deasserts, and whenever a rescan is required.
// - SCAN:
//   - chunk counter c runs 0..NumSrc/ChunkSize-1 and wraps to 0 after the last chunk.
//   - Each cycle, sources [c*ChunkSize +: ChunkSize] are reduced to one candidate.
//   - A source is eligible if pending & enable.
//   - The candidate is merged into the best register: strict > on ctl replaces it; equal ctl keeps the lower id.
//   - When c is 0, the best register is loaded rather than merged.
// - End of sweep, after the last chunk:
//   - a valid best with ctl > thresh_i (unsigned, strict) moves the FSM to OFFER next cycle;
//   - otherwise the FSM starts a new sweep immediately (SCAN, c=0).
// - Latency: pending edge to irq_valid_o is at most 2*NumSrc/ChunkSize+1 cycles; 33 at default settings.
// - OFFER:
//   - irq_valid_o=1; id, level and shv are registered and stable.
//   - The block drops irq_valid_o (withdraw) without a handshake when, for the offered id, pending_i=0, enable_i=0, or thresh_i >= level.
//   - After a withdraw, the FSM rescans the next cycle.
//   - Withdrawal is legal because the interrupt has not been taken.
//   - valid & ready: the transfer completes; irq_valid_o=0 next cycle and a new sweep starts.
//   - ready and a withdraw condition in the same cycle: ready wins and the transfer completes.
//   - A higher-level source arriving during OFFER does not preempt; it is picked up on the next sweep.
//   - irq_ready_i is ignored outside OFFER.
// - scan_busy_o=1 exactly while the FSM is in SCAN.
// CONFIGURATION
// - Macro CVA6_CLIC_SHV_EN:
//   - defined: shv_i and irq_shv_o exist; the shv bit is carried in the candidate and registered with id.
//   - undefined: both ports are absent; the candidate carries no shv bit; arbitration is otherwise identical.
// STRUCTURE
// - Package clic_scan_pkg holds:
//   - scan_state_e {IDLE, SCAN, OFFER};
//   - cand_t {logic vld; logic [SrcW-1:0] id; logic [IntCtlBits-1:0] ctl; shv under macro};
//   - function better(a,b), the ctl/id tie-break rule.
// - Sub-module clic_chunk_max:
//   - combinational log2(ChunkSize)-level reduction of ChunkSize eligibles to one cand_t;
//   - its base-id input is c*ChunkSize.
// - Top level holds the FSM, chunk counter, best register and offer register.
// TESTING
// - Single source: pending/enable id 37, ctl 0x80, thresh 0x00
//   -> valid within 33 cycles, id=37, level=0x80; ready -> valid low next cycle.
// - Tie: ids 200 and 5, both ctl 0x40 -> id 5 offered; lower id wins.
// - Priority: id 3 ctl 0x20, id 250 ctl 0xF0 -> id 250 offered.
// - Threshold: id 10 ctl 0x40 with thresh 0x40 -> never valid.
//   - Then drop thresh to 0x3F -> valid, id 10.
// - Withdraw: offered id 9; deassert pending_i[9] -> valid drops next cycle with no ready.
//   - Same cycle with ready=1 -> transfer counted.
// - Reset during SCAN at chunk 7 and during OFFER -> all outputs 0 the next cycle; sweep restarts at chunk 0.
//   - With CVA6_CLIC_SHV_EN: shv_i[37]=1 -> irq_shv_o=1 alongside id 37.

Source files
------------

// File: rtl/clic_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clic_scan_pkg
// Brief   : Shared types and tie-break rule for the CLIC interrupt scanner.
//           Optional shv field controlled by macro CVA6_CLIC_SHV_EN.
// Revision: 1.0 - initial release
// ============================================================================
package clic_scan_pkg;

    localparam int unsigned NUM_SRC      = 256;
    localparam int unsigned INT_CTL_BITS = 8;
    localparam int unsigned CHUNK_SIZE   = 16;
    localparam int unsigned SRC_W        = $clog2(NUM_SRC);
    localparam int unsigned NUM_CHUNKS   = NUM_SRC / CHUNK_SIZE;
    localparam int unsigned CHUNK_W      = $clog2(NUM_CHUNKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        OFFER = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic                    vld;
        logic [SRC_W-1:0]        id;
        logic [INT_CTL_BITS-1:0] ctl;
`ifdef CVA6_CLIC_SHV_EN
        logic                    shv;
`endif
    } cand_t;

    // True when a must displace b: higher ctl wins, equal ctl goes to the lower id.
    function automatic logic better(input cand_t a, input cand_t b);
        return a.vld && (!b.vld || (a.ctl > b.ctl) ||
                         ((a.ctl == b.ctl) && (a.id < b.id)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/clic_chunk_max.sv
`default_nettype none
// ============================================================================
// Module  : clic_chunk_max
// Brief   : Combinational max-reduction tree of one chunk of CLIC sources.
//           Carries the shv bit when macro CVA6_CLIC_SHV_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module clic_chunk_max
    import clic_scan_pkg::*;
(
    input  logic [CHUNK_SIZE-1:0]              i_elig,
    input  logic [CHUNK_SIZE*INT_CTL_BITS-1:0] i_ctl,
`ifdef CVA6_CLIC_SHV_EN
    input  logic [CHUNK_SIZE-1:0]              i_shv,
`endif
    input  logic [SRC_W-1:0]                   i_base_id,
    output cand_t                              o_cand
);

    localparam int unsigned c_LEVELS = $clog2(CHUNK_SIZE);

    for (genvar l = 0; l <= c_LEVELS; l++) begin : g_lvl
        cand_t w_node [CHUNK_SIZE >> l];

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < CHUNK_SIZE; j++) begin : g_j
                cand_t w_leaf;
                always_comb begin
                    w_leaf     = '0;
                    w_leaf.vld = i_elig[j];
                    w_leaf.id  = i_base_id + SRC_W'(j);
                    w_leaf.ctl = i_ctl[j*INT_CTL_BITS +: INT_CTL_BITS];
`ifdef CVA6_CLIC_SHV_EN
                    w_leaf.shv = i_shv[j];
`endif
                end
                assign w_node[j] = w_leaf;
            end
        end else begin : g_merge
            // Left child always holds the lower ids, so it keeps ties.
            for (genvar j = 0; j < (CHUNK_SIZE >> l); j++) begin : g_j
                assign w_node[j] =
                    better(g_lvl[l-1].w_node[2*j+1], g_lvl[l-1].w_node[2*j])
                        ? g_lvl[l-1].w_node[2*j+1] : g_lvl[l-1].w_node[2*j];
            end
        end
    end

    assign o_cand = g_lvl[c_LEVELS].w_node[0];

endmodule
`default_nettype wire

// File: rtl/clic_irq_scanner.sv
`default_nettype none
// ============================================================================
// Module  : clic_irq_scanner
// Brief   : Multi-cycle CLIC arbiter sweeping all sources chunk by chunk and
//           offering the best one above threshold to the core.
//           Macro CVA6_CLIC_SHV_EN adds shv_i / irq_shv_o.
// Revision: 1.0 - initial release
// ============================================================================
module clic_irq_scanner
    import clic_scan_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_SRC-1:0]                pending_i,
    input  logic [NUM_SRC-1:0]                enable_i,
    input  logic [NUM_SRC*INT_CTL_BITS-1:0]   ctl_i,
    input  logic [INT_CTL_BITS-1:0]           thresh_i,
    output logic                              irq_valid_o,
    output logic [SRC_W-1:0]                  irq_id_o,
    output logic [INT_CTL_BITS-1:0]           irq_level_o,
    input  logic                              irq_ready_i,
`ifdef CVA6_CLIC_SHV_EN
    output logic                              irq_shv_o,
    input  logic [NUM_SRC-1:0]                shv_i,
`endif
    output logic                              scan_busy_o
);

    scan_state_e          r_state;
    scan_state_e          w_state_nxt;
    logic [CHUNK_W-1:0]   r_chunk;
    cand_t                r_best;
    cand_t                r_offer;
    cand_t                w_cand;
    cand_t                w_merged;
    logic [SRC_W-1:0]     w_base_id;
    logic                 w_last;
    logic                 w_offer_ok;
    logic                 w_withdraw;

    assign w_base_id = {r_chunk, {(SRC_W-CHUNK_W){1'b0}}};

    clic_chunk_max u_chunk_max (
        .i_elig    (pending_i[w_base_id +: CHUNK_SIZE] & enable_i[w_base_id +: CHUNK_SIZE]),
        .i_ctl     (ctl_i[32'(w_base_id)*INT_CTL_BITS +: CHUNK_SIZE*INT_CTL_BITS]),
`ifdef CVA6_CLIC_SHV_EN
        .i_shv     (shv_i[w_base_id +: CHUNK_SIZE]),
`endif
        .i_base_id (w_base_id),
        .o_cand    (w_cand)
    );

    // Chunk 0 starts a fresh sweep, so the stale best is discarded there.
    assign w_merged   = ((r_chunk == '0) || better(w_cand, r_best)) ? w_cand : r_best;
    assign w_last     = (r_chunk == CHUNK_W'(NUM_CHUNKS-1));
    assign w_offer_ok = w_merged.vld && (w_merged.ctl > thresh_i);
    assign w_withdraw = !pending_i[r_offer.id] || !enable_i[r_offer.id] ||
                        (thresh_i >= r_offer.ctl);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = SCAN;
            SCAN:    if (w_last && w_offer_ok) w_state_nxt = OFFER;
            OFFER:   if (irq_ready_i || w_withdraw) w_state_nxt = SCAN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_chunk <= '0;
            r_best  <= '0;
            r_offer <= '0;
        end else if (r_state == SCAN) begin
            r_chunk <= r_chunk + 1'b1;
            r_best  <= w_merged;
            if (w_last && w_offer_ok) begin
                r_offer <= w_merged;
            end
        end else begin
            r_chunk <= '0;
        end
    end

    assign irq_valid_o = (r_state == OFFER);
    assign irq_id_o    = r_offer.id;
    assign irq_level_o = r_offer.ctl;
    assign scan_busy_o = (r_state == SCAN);
`ifdef CVA6_CLIC_SHV_EN
    assign irq_shv_o   = r_offer.shv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clic_irq_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_clic_irq_scanner
// Brief   : Directed self-checking bench for clic_irq_scanner
//           (covers CVA6_CLIC_SHV_EN when defined).
// Revision: 1.0 - initial release
// ============================================================================
module tb_clic_irq_scanner;
    import clic_scan_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [NUM_SRC-1:0]              pending;
    logic [NUM_SRC-1:0]              enable;
    logic [NUM_SRC*INT_CTL_BITS-1:0] ctl;
    logic [INT_CTL_BITS-1:0]         thresh;
    logic                            ready;
    logic                            irq_valid;
    logic [SRC_W-1:0]                irq_id;
    logic [INT_CTL_BITS-1:0]         irq_level;
    logic                            scan_busy;
`ifdef CVA6_CLIC_SHV_EN
    logic [NUM_SRC-1:0]              shv;
    logic                            irq_shv;
`endif

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int x0;
    bit seen;

    always #5 clk = ~clk;

    clic_irq_scanner dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pending_i   (pending),
        .enable_i    (enable),
        .ctl_i       (ctl),
        .thresh_i    (thresh),
        .irq_valid_o (irq_valid),
        .irq_id_o    (irq_id),
        .irq_level_o (irq_level),
        .irq_ready_i (ready),
`ifdef CVA6_CLIC_SHV_EN
        .irq_shv_o   (irq_shv),
        .shv_i       (shv),
`endif
        .scan_busy_o (scan_busy)
    );

    always @(posedge clk) if (irq_valid && ready) xfers++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n = 0;
        while (irq_valid !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(irq_valid), 32'd1);
    endtask

    task automatic reset_on();
        rst     = 1'b1;
        pending = '0;
        enable  = '0;
        ctl     = '0;
        thresh  = '0;
        ready   = 1'b0;
`ifdef CVA6_CLIC_SHV_EN
        shv     = '0;
`endif
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_src(input int id, input logic [7:0] lvl);
        pending[id] = 1'b1;
        enable[id]  = 1'b1;
        ctl[id*INT_CTL_BITS +: INT_CTL_BITS] = lvl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        reset_on();
        chk("rst_valid", 32'(irq_valid), 32'd0);
        chk("rst_id",    32'(irq_id),    32'd0);
        chk("rst_level", 32'(irq_level), 32'd0);
        chk("rst_busy",  32'(scan_busy), 32'd0);

        // Single source, exact latency from a fresh reset.
        set_src(37, 8'h80);
        rst = 1'b0;
        @(negedge clk);
        chk("start_busy", 32'(scan_busy), 32'd1);
        repeat (15) @(negedge clk);
        chk("lat_pre", 32'(irq_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(irq_valid), 32'd1);
        chk("s37_id",    32'(irq_id),    32'd37);
        chk("s37_level", 32'(irq_level), 32'h80);
        chk("offer_busy", 32'(scan_busy), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("ack_valid", 32'(irq_valid), 32'd0);
        chk("ack_busy",  32'(scan_busy), 32'd1);
        chk("ack_xfer",  32'(xfers),     32'd1);

        // Tie goes to the lower id.
        reset_on();
        set_src(200, 8'h40);
        set_src(5, 8'h40);
        rst = 1'b0;
        wait_valid("tie", 40);
        chk("tie_id",    32'(irq_id),    32'd5);
        chk("tie_level", 32'(irq_level), 32'h40);

        // Highest level wins regardless of id.
        reset_on();
        set_src(3, 8'h20);
        set_src(250, 8'hF0);
        rst = 1'b0;
        wait_valid("prio", 40);
        chk("prio_id",    32'(irq_id),    32'd250);
        chk("prio_level", 32'(irq_level), 32'hF0);

        // Threshold is strict: level equal to threshold is never offered.
        reset_on();
        set_src(10, 8'h40);
        thresh = 8'h40;
        rst = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (irq_valid) seen = 1'b1;
        end
        chk("thr_never", 32'(seen), 32'd0);
        thresh = 8'h3F;
        wait_valid("thr_drop", 33);
        chk("thr_id", 32'(irq_id), 32'd10);
        thresh = 8'h40;
        @(negedge clk);
        chk("thr_withdraw", 32'(irq_valid), 32'd0);

        // Withdraw on pending drop, ready-wins, withdraw on enable drop.
        reset_on();
        set_src(9, 8'h55);
        rst = 1'b0;
        wait_valid("wd", 40);
        chk("wd_id", 32'(irq_id), 32'd9);
        x0 = xfers;
        pending[9] = 1'b0;
        @(negedge clk);
        chk("wd_valid", 32'(irq_valid), 32'd0);
        chk("wd_busy",  32'(scan_busy), 32'd1);
        chk("wd_noxfer", 32'(xfers), 32'(x0));
        pending[9] = 1'b1;
        wait_valid("wd2", 40);
        pending[9] = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("wdr_valid", 32'(irq_valid), 32'd0);
        chk("wdr_xfer",  32'(xfers), 32'(x0 + 1));
        pending[9] = 1'b1;
        wait_valid("wd3", 40);
        enable[9] = 1'b0;
        @(negedge clk);
        chk("wde_valid", 32'(irq_valid), 32'd0);
        chk("wde_xfer",  32'(xfers), 32'(x0 + 1));

        // A higher source during OFFER does not preempt.
        enable[9] = 1'b1;
        wait_valid("np", 40);
        set_src(100, 8'hF0);
        repeat (5) @(negedge clk);
        chk("np_valid", 32'(irq_valid), 32'd1);
        chk("np_id",    32'(irq_id),    32'd9);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("np_ack", 32'(irq_valid), 32'd0);
        wait_valid("np2", 33);
        chk("np2_id",    32'(irq_id),    32'd100);
        chk("np2_level", 32'(irq_level), 32'hF0);

        // Reset at chunk 7, then sweep must restart from chunk 0.
        reset_on();
        set_src(37, 8'h80);
`ifdef CVA6_CLIC_SHV_EN
        shv[37] = 1'b1;
`endif
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy", 32'(scan_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 32'(irq_valid), 32'd0);
        chk("mrst_busy",  32'(scan_busy), 32'd0);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        chk("mrst_pre", 32'(irq_valid), 32'd0);
        @(negedge clk);
        chk("mrst_valid2", 32'(irq_valid), 32'd1);
        chk("mrst_id",     32'(irq_id),    32'd37);
`ifdef CVA6_CLIC_SHV_EN
        chk("shv_bit", 32'(irq_shv), 32'd1);
`endif

        // Reset while offering clears everything.
        rst = 1'b1;
        @(negedge clk);
        chk("orst_valid", 32'(irq_valid), 32'd0);
        chk("orst_id",    32'(irq_id),    32'd0);
        chk("orst_level", 32'(irq_level), 32'd0);
        chk("orst_busy",  32'(scan_busy), 32'd0);
`ifdef CVA6_CLIC_SHV_EN
        chk("orst_shv",   32'(irq_shv),   32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
